// File: rtl/arm_store_buffer.sv
// In-order store buffer between the ARM core's data write port and a slower memory.
// Captures one store per cycle, coalesces repeat stores to the youngest word and forwards to loads.
module arm_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [ADDR_W-1:0]          DataAdr,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic [ADDR_W-1:0]          LdAdr,
  output logic                       LdHit,
  output logic [DATA_W-1:0]          LdData,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  cnt;
  logic              overflowQ;

  logic              pop;
  logic              coalesce;
  logic              append;
  logic              drop;
  logic [PTR_W-1:0]  youngIdx;

  // Push/pop decision; coalesce only onto an entry that is not leaving this cycle
  always_comb begin
    youngIdx = tailPtr - PTR_W'(1);
    pop      = (cnt != CNT_W'(0)) && mem_ready;
    coalesce = MemWrite && (cnt != CNT_W'(0)) && (DataAdr == addrMem[youngIdx])
               && !((cnt == CNT_W'(1)) && pop);
    append   = MemWrite && !coalesce && ((cnt < CNT_W'(DEPTH)) || pop);
    drop     = MemWrite && !coalesce && !append;
  end

  // Storage, pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addrMem[i] <= '0;
        dataMem[i] <= '0;
      end
      headPtr   <= '0;
      tailPtr   <= '0;
      cnt       <= '0;
      overflowQ <= 1'b0;
    end else begin
      if (append) begin
        addrMem[tailPtr] <= DataAdr;
        dataMem[tailPtr] <= WriteData;
        tailPtr          <= tailPtr + PTR_W'(1);
      end else if (coalesce) begin
        dataMem[youngIdx] <= WriteData;
      end
      if (pop) headPtr <= headPtr + PTR_W'(1);
      if (append && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !append) cnt <= cnt - CNT_W'(1);
      if (drop) overflowQ <= 1'b1;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    LdHit  = 1'b0;
    LdData = '0;
    idx    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = headPtr + PTR_W'(i);
      if ((CNT_W'(i) < cnt) && (addrMem[idx] == LdAdr)) begin
        LdHit  = 1'b1;
        LdData = dataMem[idx];
      end
    end
  end

  assign Count     = cnt;
  assign Full      = (cnt == CNT_W'(DEPTH));
  assign Empty     = (cnt == CNT_W'(0));
  assign Overflow  = overflowQ;
  assign mem_valid = (cnt != CNT_W'(0));
  assign mem_addr  = addrMem[headPtr];
  assign mem_wdata = dataMem[headPtr];

endmodule

// File: tb/tb_arm_store_buffer.sv
// Directed vector bench for arm_store_buffer: table of post-edge expectations plus
// hand-written sequences for same-cycle forwarding and asynchronous reset mid-drain.
module tb_arm_store_buffer;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] LdAdr;
  logic        LdHit;
  logic [31:0] LdData;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;
  logic        Overflow;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  arm_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .LdAdr(LdAdr), .LdHit(LdHit), .LdData(LdData),
    .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] ld;
    int          cnt;
    logic [31:0] hAddr;
    logic [31:0] hData;
    logic        ovf;
    logic        hit;
    logic [31:0] ldData;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic we, input logic [31:0] adr,
                        input logic [31:0] wd, input logic rdy, input logic [31:0] ld,
                        input int cnt, input logic [31:0] hAddr, input logic [31:0] hData,
                        input logic ovf, input logic hit, input logic [31:0] ldData);
    vec_t v;
    v.rst = rst; v.we = we; v.adr = adr; v.wd = wd; v.rdy = rdy; v.ld = ld;
    v.cnt = cnt; v.hAddr = hAddr; v.hData = hData; v.ovf = ovf; v.hit = hit;
    v.ldData = ldData;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0; mem_ready = 1'b0;
  endtask

  task automatic checkState(input string tag, input int cnt, input logic [31:0] hAddr,
                            input logic [31:0] hData, input logic ovf);
    check({tag, ".Count"}, 32'(Count), 32'(cnt));
    check({tag, ".mem_valid"}, 32'(mem_valid), 32'(cnt != 0));
    check({tag, ".Empty"}, 32'(Empty), 32'(cnt == 0));
    check({tag, ".Full"}, 32'(Full), 32'(cnt == 4));
    check({tag, ".Overflow"}, 32'(Overflow), 32'(ovf));
    if (cnt != 0) begin
      check({tag, ".mem_addr"}, mem_addr, hAddr);
      check({tag, ".mem_wdata"}, mem_wdata, hData);
    end
  endtask

  initial begin
    idle();
    LdAdr = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, all outputs cleared
    check("rst.Count", 32'(Count), 32'd0);
    check("rst.Empty", 32'(Empty), 32'd1);
    check("rst.Full", 32'(Full), 32'd0);
    check("rst.mem_valid", 32'(mem_valid), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.LdHit", 32'(LdHit), 32'd0);
    check("rst.LdData", LdData, 32'd0);
    check("rst.Overflow", 32'(Overflow), 32'd0);
    reset = 1'b1;

    //     rst we adr    wd     rdy ld     cnt hAddr  hData  ovf hit ldData
    // single store then drain
    addVec(0, 1, 100,   7,     0,  100,   1,  100,   7,     0,  1,  7);
    addVec(0, 0, 0,     0,     1,  100,   0,  0,     0,     0,  0,  0);
    // fill, overflow, in-order drain
    addVec(0, 1, 'h60,  1,     0,  'h64,  1,  'h60,  1,     0,  0,  0);
    addVec(0, 1, 'h64,  2,     0,  'h64,  2,  'h60,  1,     0,  1,  2);
    addVec(0, 1, 'h68,  3,     0,  'h64,  3,  'h60,  1,     0,  1,  2);
    addVec(0, 1, 'h6C,  4,     0,  'h64,  4,  'h60,  1,     0,  1,  2);
    addVec(0, 1, 'h70,  5,     0,  'h70,  4,  'h60,  1,     1,  0,  0);
    addVec(0, 0, 0,     0,     1,  'h6C,  3,  'h64,  2,     1,  1,  4);
    addVec(0, 0, 0,     0,     1,  'h6C,  2,  'h68,  3,     1,  1,  4);
    addVec(0, 0, 0,     0,     1,  'h6C,  1,  'h6C,  4,     1,  1,  4);
    addVec(0, 0, 0,     0,     1,  'h6C,  0,  0,     0,     1,  0,  0);
    // adjacent coalesce
    addVec(1, 1, 'h60,  1,     0,  'h60,  1,  'h60,  1,     0,  1,  1);
    addVec(0, 1, 'h60,  2,     0,  'h60,  1,  'h60,  2,     0,  1,  2);
    // non-adjacent repeat does not coalesce
    addVec(1, 1, 'h60,  1,     0,  'h60,  1,  'h60,  1,     0,  1,  1);
    addVec(0, 1, 'h64,  5,     0,  'h60,  2,  'h60,  1,     0,  1,  1);
    addVec(0, 1, 'h60,  9,     0,  'h60,  3,  'h60,  1,     0,  1,  9);
    // fill, coalesce while Full, then push+pop while Full
    addVec(1, 1, 'h10,  11,    0,  'h80,  1,  'h10,  11,    0,  0,  0);
    addVec(0, 1, 'h14,  12,    0,  'h80,  2,  'h10,  11,    0,  0,  0);
    addVec(0, 1, 'h18,  13,    0,  'h80,  3,  'h10,  11,    0,  0,  0);
    addVec(0, 1, 'h1C,  14,    0,  'h1C,  4,  'h10,  11,    0,  1,  14);
    addVec(0, 1, 'h1C,  'h99,  0,  'h1C,  4,  'h10,  11,    0,  1,  'h99);
    addVec(0, 1, 'h80,  'h88,  1,  'h80,  4,  'h14,  12,    0,  1,  'h88);
    addVec(0, 0, 0,     0,     1,  'h80,  3,  'h18,  13,    0,  1,  'h88);
    addVec(0, 0, 0,     0,     1,  'h80,  2,  'h1C,  'h99,  0,  1,  'h88);
    addVec(0, 0, 0,     0,     1,  'h80,  1,  'h80,  'h88,  0,  1,  'h88);
    addVec(0, 0, 0,     0,     1,  'h80,  0,  0,     0,     0,  0,  0);
    // count==1 push+pop to the same address appends
    addVec(1, 1, 'h40,  1,     0,  'h40,  1,  'h40,  1,     0,  1,  1);
    addVec(0, 1, 'h40,  2,     1,  'h40,  1,  'h40,  2,     0,  1,  2);
    // forwarding: youngest match wins, miss returns zero
    addVec(1, 1, 'h60,  3,     0,  'h60,  1,  'h60,  3,     0,  1,  3);
    addVec(0, 1, 'h64,  4,     0,  'h60,  2,  'h60,  3,     0,  1,  3);
    addVec(0, 1, 'h60,  8,     0,  'h60,  3,  'h60,  3,     0,  1,  8);
    addVec(0, 0, 0,     0,     0,  'h68,  3,  'h60,  3,     0,  0,  0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge clk);
      if (vecs[i].rst) begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      MemWrite = vecs[i].we; DataAdr = vecs[i].adr; WriteData = vecs[i].wd;
      mem_ready = vecs[i].rdy; LdAdr = vecs[i].ld;
      @(posedge clk);
      #1;
      checkState(tag, vecs[i].cnt, vecs[i].hAddr, vecs[i].hData, vecs[i].ovf);
      check({tag, ".LdHit"}, 32'(LdHit), 32'(vecs[i].hit));
      check({tag, ".LdData"}, LdData, vecs[i].ldData);
    end

    // An incoming store is not forwarded in its own cycle
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    MemWrite = 1'b1; DataAdr = 'h200; WriteData = 'h55; LdAdr = 'h200;
    #1;
    check("samecyc.LdHit_pre", 32'(LdHit), 32'd0);
    check("samecyc.LdData_pre", LdData, 32'd0);
    @(posedge clk);
    #1;
    check("samecyc.LdHit_post", 32'(LdHit), 32'd1);
    check("samecyc.LdData_post", LdData, 32'h55);

    // Asynchronous reset in the middle of a drain
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      MemWrite = 1'b1; DataAdr = 32'('h30 + 4 * k); WriteData = 32'(k + 1);
      @(negedge clk);
    end
    MemWrite = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    checkState("midrain", 2, 'h34, 2, 0);
    mem_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("arst.mem_valid", 32'(mem_valid), 32'd0);
    check("arst.Count", 32'(Count), 32'd0);
    check("arst.Empty", 32'(Empty), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    LdAdr = 'h38;
    repeat (2) @(posedge clk);
    #1;
    check("arst.replay_valid", 32'(mem_valid), 32'd0);
    check("arst.replay_count", 32'(Count), 32'd0);
    check("arst.replay_LdHit", 32'(LdHit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
